// File: rtl/rat_reg_file_if.sv
// Register-file access bundle: write port, two read ports and status flags.
interface rat_reg_file_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              CLR;
  logic              RF_WR;
  logic [ADDR_W-1:0] ADRX;
  logic [ADDR_W-1:0] ADRY;
  logic [DATA_W-1:0] DIN;
  logic [DATA_W-1:0] DX_OUT;
  logic [DATA_W-1:0] DY_OUT;
  logic              BUSY;
  logic              WR_DROP;

  modport master (
    output CLR, RF_WR, ADRX, ADRY, DIN,
    input  DX_OUT, DY_OUT, BUSY, WR_DROP
  );

  modport slave (
    input  CLR, RF_WR, ADRX, ADRY, DIN,
    output DX_OUT, DY_OUT, BUSY, WR_DROP
  );
endinterface

// File: rtl/rat_reg_file.sv
// RAT MCU 32x8 register file with sequenced clear engine and two combinational read ports.
// Optional same-cycle write-to-read bypass: define RAT_RF_WR_BYPASS_EN.
module rat_reg_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic          CLK,
  input  logic          RST_N,
  rat_reg_file_if.slave bus
);
  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEARING = 1'b1} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_drop_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic busy, wr_ok, wr_rej;
  assign busy   = (state == CLEARING);
  assign wr_ok  = !busy && bus.RF_WR && !bus.CLR;
  assign wr_rej = bus.RF_WR && (busy || bus.CLR);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= CLEARING;
      clr_idx   <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= wr_rej;
      if (bus.CLR) begin
        // a request mid-clear simply restarts the sweep
        state   <= CLEARING;
        clr_idx <= '0;
      end else if (state == CLEARING) begin
        clr_idx <= clr_idx + 1'b1;
        if (clr_idx == LAST) state <= IDLE;
      end
    end
  end

  // No reset on storage so it can map onto distributed RAM; the sweep zeroes it.
  always_ff @(posedge CLK) begin
    if (busy)       mem[clr_idx]  <= '0;
    else if (wr_ok) mem[bus.ADRX] <= bus.DIN;
  end

  always_comb begin
    bus.DX_OUT = '0;
    bus.DY_OUT = '0;
    if (!busy) begin
      bus.DX_OUT = mem[bus.ADRX];
      bus.DY_OUT = mem[bus.ADRY];
`ifdef RAT_RF_WR_BYPASS_EN
      if (wr_ok) begin
        bus.DX_OUT = bus.DIN;
        if (bus.ADRY == bus.ADRX) bus.DY_OUT = bus.DIN;
      end
`endif
    end
  end

  assign bus.BUSY    = busy;
  assign bus.WR_DROP = wr_drop_q;
endmodule

// File: tb/tb_rat_reg_file.sv
// Directed self-checking bench for rat_reg_file: clear timing, writes, rejections, bypass.
module tb_rat_reg_file;
  logic CLK = 1'b0;
  logic RST_N;
  int checks = 0;
  int failures = 0;
  logic [7:0] model [32];

  rat_reg_file_if #(.DATA_W(8), .ADDR_W(5)) bus ();

  rat_reg_file #(.DATA_W(8), .ADDR_W(5)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one rising edge, then settle 1 time unit into the cycle
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.RF_WR = 1'b1; bus.ADRX = a; bus.DIN = d;
    tick();
    bus.RF_WR = 1'b0;
  endtask

  // called one slot after the clear begins (or reset release): expects 32 more edges of BUSY
  task automatic clear_window(input string tag);
    repeat (31) tick();
    chk({tag, "_busy_at31"}, 32'(bus.BUSY), 32'd1);
    tick();
    chk({tag, "_idle_at32"}, 32'(bus.BUSY), 32'd0);
  endtask

  initial begin
    RST_N = 1'b0;
    bus.CLR = 1'b0; bus.RF_WR = 1'b0; bus.ADRX = '0; bus.ADRY = '0; bus.DIN = '0;
    tick();
    chk("rst_busy", 32'(bus.BUSY), 32'd1);
    chk("rst_dx", 32'(bus.DX_OUT), 32'd0);
    chk("rst_wrdrop", 32'(bus.WR_DROP), 32'd0);
    tick();
    RST_N = 1'b1;
    clear_window("init");

    // preload nonzero random data
    for (int a = 0; a < 32; a++) begin
      model[a] = 8'($urandom_range(1, 255));
      wr(5'(a), model[a]);
    end
    bus.ADRX = 5'd3; bus.ADRY = 5'd30; #1;
    chk("preload_dx3", 32'(bus.DX_OUT), 32'(model[3]));
    chk("preload_dy30", 32'(bus.DY_OUT), 32'(model[30]));

    // reset pulse of 3 cycles, outputs forced to zero while held
    RST_N = 1'b0; #1;
    chk("rst2_busy", 32'(bus.BUSY), 32'd1);
    chk("rst2_dx", 32'(bus.DX_OUT), 32'd0);
    chk("rst2_dy", 32'(bus.DY_OUT), 32'd0);
    repeat (3) tick();
    RST_N = 1'b1;
    clear_window("rst2");
    for (int a = 0; a < 32; a++) begin
      bus.ADRX = 5'(a); bus.ADRY = 5'(31 - a); #1;
      chk($sformatf("zero_dx%0d", a), 32'(bus.DX_OUT), 32'd0);
      chk($sformatf("zero_dy%0d", 31 - a), 32'(bus.DY_OUT), 32'd0);
    end

    // basic write / read
    wr(5'd5, 8'hA5);
    wr(5'd31, 8'h3C);
    bus.ADRX = 5'd5; bus.ADRY = 5'd31; #1;
    chk("rd_dx5", 32'(bus.DX_OUT), 32'hA5);
    chk("rd_dy31", 32'(bus.DY_OUT), 32'h3C);
    chk("rd_nodrop", 32'(bus.WR_DROP), 32'd0);
    bus.ADRY = 5'd5; #1;
    chk("same_dx", 32'(bus.DX_OUT), 32'hA5);
    chk("same_dy", 32'(bus.DY_OUT), 32'hA5);

    // write during clear, at clear edge 10
    bus.CLR = 1'b1;
    tick();
    bus.CLR = 1'b0;
    chk("clr_busy", 32'(bus.BUSY), 32'd1);
    repeat (9) tick();
    bus.RF_WR = 1'b1; bus.ADRX = 5'd7; bus.ADRY = 5'd7; bus.DIN = 8'hFF; #1;
    chk("busy_dx_zero", 32'(bus.DX_OUT), 32'd0);
    tick();
    bus.RF_WR = 1'b0;
    chk("busy_wrdrop", 32'(bus.WR_DROP), 32'd1);
    tick();
    chk("busy_wrdrop_1cyc", 32'(bus.WR_DROP), 32'd0);
    repeat (20) tick();
    chk("clr_busy_at31", 32'(bus.BUSY), 32'd1);
    tick();
    chk("clr_idle_at32", 32'(bus.BUSY), 32'd0);
    chk("drop_entry7", 32'(bus.DX_OUT), 32'd0);
    bus.ADRX = 5'd5; #1;
    chk("cleared_entry5", 32'(bus.DX_OUT), 32'd0);

    // CLR colliding with a write in IDLE, then CLR restart at clear edge 20
    wr(5'd2, 8'h77);
    bus.ADRX = 5'd2; bus.ADRY = 5'd2; bus.DIN = 8'h11; bus.RF_WR = 1'b1; bus.CLR = 1'b1; #1;
    chk("coll_no_bypass", 32'(bus.DX_OUT), 32'h77);
    tick();
    bus.RF_WR = 1'b0; bus.CLR = 1'b0;
    chk("coll_wrdrop", 32'(bus.WR_DROP), 32'd1);
    chk("coll_busy", 32'(bus.BUSY), 32'd1);
    repeat (19) tick();
    bus.CLR = 1'b1;
    tick();
    bus.CLR = 1'b0;
    clear_window("restart");
    chk("coll_entry2", 32'(bus.DX_OUT), 32'd0);

    // async reset mid-clear, between edges at clear edge 15
    bus.CLR = 1'b1;
    tick();
    bus.CLR = 1'b0;
    repeat (14) tick();
    #2 RST_N = 1'b0; #1;
    chk("amid_busy", 32'(bus.BUSY), 32'd1);
    chk("amid_dx", 32'(bus.DX_OUT), 32'd0);
    tick();
    tick();
    RST_N = 1'b1;
    clear_window("amid");

    // same-cycle visibility of a write
    wr(5'd9, 8'h00);
    bus.ADRX = 5'd9; bus.ADRY = 5'd9; bus.DIN = 8'h42; bus.RF_WR = 1'b1; #1;
`ifdef RAT_RF_WR_BYPASS_EN
    chk("byp_dx", 32'(bus.DX_OUT), 32'h42);
    chk("byp_dy", 32'(bus.DY_OUT), 32'h42);
`else
    chk("byp_dx", 32'(bus.DX_OUT), 32'h00);
    chk("byp_dy", 32'(bus.DY_OUT), 32'h00);
`endif
    tick();
    bus.RF_WR = 1'b0; #1;
    chk("next_dx", 32'(bus.DX_OUT), 32'h42);
    chk("next_dy", 32'(bus.DY_OUT), 32'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rat_reg_file.md
Name: rat_reg_file

Overview:
- 32x8 general-purpose register file for the RAT MCU.
- Sits directly downstream of the register-file write-data mux: that mux's selected 8-bit result arrives on DIN.
- Provides two combinational read ports, X and Y, which feed the ALU operand path.
- Contains a sequenced clear engine that zeroes every entry after reset or on request, so no per-entry asynchronous reset is needed and the storage can map to distributed RAM.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 5, address width in bits. DEPTH = 2**ADDR_W is derived internally and is not overridable.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- CLR  input  1  synchronous request to re-zero the whole file.
- RF_WR  input  1  write enable.
- ADRX  input  ADDR_W  write address and X read address.
- ADRY  input  ADDR_W  Y read address.
- DIN  input  DATA_W  write data from the write-data mux.
- DX_OUT  output  DATA_W  contents of entry ADRX.
- DY_OUT  output  DATA_W  contents of entry ADRY.
- BUSY  output  1  clear sequence in progress.
- WR_DROP  output  1  registered one-cycle flag: a write was rejected.

Behaviour:
- Clock and reset are fixed: one clock (CLK); reset is asynchronous and active-low (RST_N).
- State machine has two states, CLEARING and IDLE. A clear counter clr_idx is ADDR_W bits wide.
- RST_N low, asynchronous:
  - state = CLEARING, clr_idx = 0, WR_DROP = 0.
  - BUSY = 1 immediately; DX_OUT/DY_OUT = 0 immediately.
  - Storage contents are not touched by reset itself.
- CLEARING, each rising edge: mem[clr_idx] <= 0 and clr_idx increments.
  - On the edge where clr_idx == DEPTH-1, the final entry is written and state -> IDLE.
  - Exactly DEPTH cycles after RST_N deasserts, BUSY = 0.
- CLR sampled high:
  - In IDLE: state -> CLEARING, clr_idx = 0. BUSY rises the following cycle. Clearing takes DEPTH cycles.
  - In CLEARING: clr_idx restarts at 0, so the sequence restarts.
- While BUSY = 1: DX_OUT = DY_OUT = 0, regardless of storage contents.
- Write, IDLE only: on a rising edge with RF_WR = 1 and CLR = 0, mem[ADRX] <= DIN. The new value is visible on the read ports from the next cycle.
- Write rejection: RF_WR = 1 while BUSY = 1, or together with CLR = 1 in IDLE:
  - The write is ignored.
  - WR_DROP = 1 for exactly the next cycle; otherwise WR_DROP = 0.
- Reads are combinational, zero latency: DX_OUT = mem[ADRX], DY_OUT = mem[ADRY]. ADRX == ADRY is legal and both ports return the same value.
- Widths are exact; there is no arithmetic. clr_idx wraps naturally but never advances past DEPTH-1.
- Reset mid-clear or mid-write: the sequence restarts from clr_idx = 0; any in-flight write is lost.

Optional Feature:
- Macro: RAT_RF_WR_BYPASS_EN.
- Defined: when state is IDLE and RF_WR = 1, DX_OUT = DIN in the same cycle. DY_OUT = DIN as well when ADRY == ADRX. This bypass is suppressed while BUSY = 1 or CLR = 1.
- Undefined: read ports always show stored contents; a same-cycle write becomes visible one cycle later.

Test Plan:
- Reset and clear: preload random data, pulse RST_N low for 3 cycles -> BUSY = 1 and outputs 0 during reset; BUSY falls exactly 32 cycles after RST_N deasserts; all 32 entries then read 0x00.
- Basic write/read: write 0xA5 to 5 and 0x3C to 31 -> next cycle, ADRX=5/ADRY=31 give DX_OUT=0xA5, DY_OUT=0x3C; ADRX=ADRY=5 gives 0xA5 on both.
- Write during clear: RF_WR=1, ADRX=7, DIN=0xFF at cycle 10 of the clear -> WR_DROP=1 for one cycle; entry 7 reads 0x00 after BUSY falls.
- CLR collision: in IDLE, CLR=1 with RF_WR=1, ADRX=2, DIN=0x11 -> write dropped, WR_DROP=1, BUSY=1 next cycle; CLR again at clear cycle 20 -> BUSY lasts 32 cycles from the restart.
- Async reset mid-clear: drop RST_N between clock edges at clear cycle 15 -> BUSY stays 1; a full 32-cycle clear follows release.
- Bypass, with macro: RF_WR=1, ADRX=ADRY=9, DIN=0x42 -> DX_OUT=DY_OUT=0x42 in the same cycle. Without macro: both show the old value 0x00 in that cycle and 0x42 on the next.
